// File: rtl/canv_mixer_pkg.sv
// canv_mixer_pkg -- shared definitions for the canvas layer mixer.
//
// Holds the layout of the 32-bit configuration word, the legal
// bits-per-pixel encodings, the per-layer configuration record, the
// reset configuration and small decode helpers.
//
// Configuration word layout:
//   [3:0]   bpp        bits per pixel (1, 2, 4 or 8)
//   [4]     enable     layer enable
//   [5]     trans_en   transparency key enable
//   [15:8]  trans_idx  transparent raw index
//   [23:16] pal_off    palette offset added to the raw index
package canv_mixer_pkg;

    localparam int CFG_BPP_LSB  = 0;
    localparam int CFG_EN_BIT   = 4;
    localparam int CFG_TEN_BIT  = 5;
    localparam int CFG_TIDX_LSB = 8;
    localparam int CFG_PAL_LSB  = 16;

    localparam logic [3:0] BPP_1 = 4'd1;
    localparam logic [3:0] BPP_2 = 4'd2;
    localparam logic [3:0] BPP_4 = 4'd4;
    localparam logic [3:0] BPP_8 = 4'd8;

    typedef struct packed {
        logic       enable;
        logic       trans_en;
        logic [7:0] trans_idx;
        logic [7:0] pal_off;
        logic [3:0] bpp;
    } layer_cfg_t;

    // Layer 0 comes out of reset visible so the screen shows something
    // before software has configured anything.
    localparam layer_cfg_t CFG_RST_L0 = '{enable: 1'b1, trans_en: 1'b0,
                                          trans_idx: 8'h00, pal_off: 8'h00,
                                          bpp: BPP_4};
    localparam layer_cfg_t CFG_RST_LN = '{enable: 1'b0, trans_en: 1'b0,
                                          trans_idx: 8'h00, pal_off: 8'h00,
                                          bpp: BPP_4};

    function automatic logic bpp_valid(input logic [3:0] b);
        logic ok;
        case (b)
            BPP_1, BPP_2, BPP_4, BPP_8: ok = 1'b1;
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // log2 of a legal bpp; only legal encodings ever reach a config register.
    function automatic logic [1:0] bpp_log2(input logic [3:0] b);
        logic [1:0] l;
        case (b)
            BPP_1:   l = 2'd0;
            BPP_2:   l = 2'd1;
            BPP_4:   l = 2'd2;
            default: l = 2'd3;
        endcase
        return l;
    endfunction

    function automatic layer_cfg_t cfg_decode(input logic [31:0] d);
        layer_cfg_t c;
        c.bpp       = d[CFG_BPP_LSB +: 4];
        c.enable    = d[CFG_EN_BIT];
        c.trans_en  = d[CFG_TEN_BIT];
        c.trans_idx = d[CFG_TIDX_LSB +: 8];
        c.pal_off   = d[CFG_PAL_LSB +: 8];
        return c;
    endfunction

endpackage

// File: rtl/canv_mixer_pix_extract.sv
// canv_pix_extract -- stage 1 of the mixer for a single layer.
//
// Picks the pixel selected by pid out of a vram word, decides whether
// the layer is visible at this pixel and registers the visibility flag
// together with the palette-offset colour index.
//
// Ports:
//   clk, rst                   pixel clock, synchronous active-high reset
//   word                       vram word for this layer
//   pid                        pixel ID within the word (masked by bpp)
//   paint                      window paint for this layer
//   enable, trans_en,
//   trans_idx, pal_off, bpp    active configuration of this layer
//   vis                        registered: layer covers this pixel
//   cidx                       registered: raw + pal_off, wrapped
module canv_pix_extract
    import canv_mixer_pkg::*;
#(
    parameter int WORD       = 32,
    parameter int PIX_IDW    = 5,
    parameter int CIDX_ADDRW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD-1:0]       word,
    input  logic [PIX_IDW-1:0]    pid,
    input  logic                  paint,
    input  logic                  enable,
    input  logic                  trans_en,
    input  logic [7:0]            trans_idx,
    input  logic [7:0]            pal_off,
    input  logic [3:0]            bpp,
    output logic                  vis,
    output logic [CIDX_ADDRW-1:0] cidx
);

    logic                  vis_d, vis_q;
    logic [CIDX_ADDRW-1:0] cidx_d, cidx_q;

    logic [1:0]  lg;
    logic [31:0] slots_m1;
    logic [31:0] shift;
    logic [7:0]  mask;
    logic [7:0]  raw;

    always_comb begin
        lg       = bpp_log2(bpp);
        // Pixels per word is WORD/bpp; masking pid with (slots-1) keeps the
        // shift inside the word.
        slots_m1 = (32'(WORD) >> lg) - 32'd1;
        shift    = (32'(pid) & slots_m1) << lg;
        mask     = 8'((9'd1 << bpp) - 9'd1);
        raw      = 8'(word >> shift) & mask;
        // Transparency keys on the raw index, before the palette offset.
        vis_d    = paint & enable & ~(trans_en & (raw == trans_idx));
        cidx_d   = CIDX_ADDRW'({1'b0, raw} + {1'b0, pal_off});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vis_q  <= 1'b0;
            cidx_q <= '0;
        end else begin
            vis_q  <= vis_d;
            cidx_q <= cidx_d;
        end
    end

    assign vis  = vis_q;
    assign cidx = cidx_q;

endmodule

// File: rtl/canv_mixer.sv
// canv_mixer -- multi-layer indexed-colour canvas mixer.
//
// Each layer supplies a vram word and pixel ID; the lowest-numbered
// visible layer wins and its colour index (plus palette offset) is
// presented as the CLUT address two cycles later, with display timing
// delayed to match. Layer configuration is double-buffered: writes land
// in a pending copy that becomes active on frame_start.
//
// Ports:
//   clk_pix, rst_pix                    pixel clock, sync active-high reset
//   frame_start                         pending config -> active config
//   cfg_we, cfg_sel, cfg_data           configuration write port
//   vram_dout, pix_id, paint            per-layer pixel inputs
//   de_in, hsync_in, vsync_in           display timing in
//   clut_addr, opaque, layer_id         mixed pixel out (2-cycle latency)
//   de_out, hsync_out, vsync_out        display timing out (2-cycle delay)
//   cfg_err                             sticky illegal-write flag
module canv_mixer
    import canv_mixer_pkg::*;
#(
    parameter int LAYERS     = 2,
    parameter int WORD       = 32,
    parameter int PIX_IDW    = 5,
    parameter int CIDX_ADDRW = 8
) (
    input  logic                      clk_pix,
    input  logic                      rst_pix,
    input  logic                      frame_start,
    input  logic                      cfg_we,
    input  logic [1:0]                cfg_sel,
    input  logic [31:0]               cfg_data,
    input  logic [LAYERS*WORD-1:0]    vram_dout,
    input  logic [LAYERS*PIX_IDW-1:0] pix_id,
    input  logic [LAYERS-1:0]         paint,
    input  logic                      de_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    output logic [CIDX_ADDRW-1:0]     clut_addr,
    output logic                      opaque,
    output logic [1:0]                layer_id,
    output logic                      de_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      cfg_err
);

    // ---------------- configuration ----------------
    layer_cfg_t pend_d [LAYERS];
    layer_cfg_t pend_q [LAYERS];
    layer_cfg_t act_d  [LAYERS];
    layer_cfg_t act_q  [LAYERS];
    logic       cfg_err_d, cfg_err_q;

    layer_cfg_t wr_cfg;
    logic       wr_ok;

    always_comb begin
        wr_cfg    = cfg_decode(cfg_data);
        wr_ok     = cfg_we && (int'(cfg_sel) < LAYERS) && bpp_valid(wr_cfg.bpp);
        cfg_err_d = cfg_err_q | (cfg_we & ~wr_ok);
        for (int i = 0; i < LAYERS; i++) begin
            pend_d[i] = pend_q[i];
            if (wr_ok && (int'(cfg_sel) == i)) begin
                pend_d[i] = wr_cfg;
            end
            // Taking pend_d (not pend_q) folds a same-cycle write into the
            // newly active copy.
            act_d[i] = frame_start ? pend_d[i] : act_q[i];
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            for (int i = 0; i < LAYERS; i++) begin
                pend_q[i] <= (i == 0) ? CFG_RST_L0 : CFG_RST_LN;
                act_q[i]  <= (i == 0) ? CFG_RST_L0 : CFG_RST_LN;
            end
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < LAYERS; i++) begin
                pend_q[i] <= pend_d[i];
                act_q[i]  <= act_d[i];
            end
            cfg_err_q <= cfg_err_d;
        end
    end

    // ---------------- stage 1: per-layer extraction ----------------
    logic [LAYERS-1:0]     vis_s1;
    logic [CIDX_ADDRW-1:0] cidx_s1 [LAYERS];

    for (genvar g = 0; g < LAYERS; g++) begin : g_layer
        canv_pix_extract #(
            .WORD       (WORD),
            .PIX_IDW    (PIX_IDW),
            .CIDX_ADDRW (CIDX_ADDRW)
        ) u_extract (
            .clk       (clk_pix),
            .rst       (rst_pix),
            .word      (vram_dout[g*WORD +: WORD]),
            .pid       (pix_id[g*PIX_IDW +: PIX_IDW]),
            .paint     (paint[g]),
            .enable    (act_q[g].enable),
            .trans_en  (act_q[g].trans_en),
            .trans_idx (act_q[g].trans_idx),
            .pal_off   (act_q[g].pal_off),
            .bpp       (act_q[g].bpp),
            .vis       (vis_s1[g]),
            .cidx      (cidx_s1[g])
        );
    end

    logic de_s1_d, de_s1_q, hs_s1_d, hs_s1_q, vs_s1_d, vs_s1_q;

    // ---------------- stage 2: priority select ----------------
    logic [CIDX_ADDRW-1:0] clut_d, clut_q;
    logic                  opaque_d, opaque_q;
    logic [1:0]            lid_d, lid_q;
    logic                  de_s2_d, de_s2_q, hs_s2_d, hs_s2_q, vs_s2_d, vs_s2_q;

    always_comb begin
        de_s1_d  = de_in;
        hs_s1_d  = hsync_in;
        vs_s1_d  = vsync_in;
        de_s2_d  = de_s1_q;
        hs_s2_d  = hs_s1_q;
        vs_s2_d  = vs_s1_q;
        clut_d   = '0;
        opaque_d = 1'b0;
        lid_d    = 2'd0;
        // Walk from the highest layer down so the lowest visible one is
        // the last to write, i.e. layer 0 has top priority.
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (vis_s1[i]) begin
                clut_d   = cidx_s1[i];
                opaque_d = 1'b1;
                lid_d    = 2'(i);
            end
        end
        // Blanking: pixel outputs are held at zero outside active video.
        if (!de_s1_q) begin
            clut_d   = '0;
            opaque_d = 1'b0;
            lid_d    = 2'd0;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            de_s1_q  <= 1'b0;
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            de_s2_q  <= 1'b0;
            hs_s2_q  <= 1'b0;
            vs_s2_q  <= 1'b0;
            clut_q   <= '0;
            opaque_q <= 1'b0;
            lid_q    <= 2'd0;
        end else begin
            de_s1_q  <= de_s1_d;
            hs_s1_q  <= hs_s1_d;
            vs_s1_q  <= vs_s1_d;
            de_s2_q  <= de_s2_d;
            hs_s2_q  <= hs_s2_d;
            vs_s2_q  <= vs_s2_d;
            clut_q   <= clut_d;
            opaque_q <= opaque_d;
            lid_q    <= lid_d;
        end
    end

    assign clut_addr = clut_q;
    assign opaque    = opaque_q;
    assign layer_id  = lid_q;
    assign de_out    = de_s2_q;
    assign hsync_out = hs_s2_q;
    assign vsync_out = vs_s2_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_canv_mixer.sv
// tb_canv_mixer -- directed and random bench for canv_mixer (LAYERS=2).
module tb_canv_mixer;

    localparam int LAYERS     = 2;
    localparam int WORD       = 32;
    localparam int PIX_IDW    = 5;
    localparam int CIDX_ADDRW = 8;
    localparam int EW         = CIDX_ADDRW + 6;

    // ---------------- clock / reset / DUT ----------------
    logic                      clk_pix = 1'b0;
    logic                      rst_pix;
    logic                      frame_start;
    logic                      cfg_we;
    logic [1:0]                cfg_sel;
    logic [31:0]               cfg_data;
    logic [LAYERS*WORD-1:0]    vram_dout;
    logic [LAYERS*PIX_IDW-1:0] pix_id;
    logic [LAYERS-1:0]         paint;
    logic                      de_in, hsync_in, vsync_in;
    logic [CIDX_ADDRW-1:0]     clut_addr;
    logic                      opaque;
    logic [1:0]                layer_id;
    logic                      de_out, hsync_out, vsync_out;
    logic                      cfg_err;

    always #5 clk_pix = ~clk_pix;

    canv_mixer #(
        .LAYERS     (LAYERS),
        .WORD       (WORD),
        .PIX_IDW    (PIX_IDW),
        .CIDX_ADDRW (CIDX_ADDRW)
    ) dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .frame_start (frame_start),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .vram_dout   (vram_dout),
        .pix_id      (pix_id),
        .paint       (paint),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .clut_addr   (clut_addr),
        .opaque      (opaque),
        .layer_id    (layer_id),
        .de_out      (de_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .cfg_err     (cfg_err)
    );

    // ---------------- reference model ----------------
    int total = 0;
    int bad   = 0;

    int m_pend_bpp [LAYERS], m_pend_en [LAYERS], m_pend_ten [LAYERS];
    int m_pend_tidx[LAYERS], m_pend_pal[LAYERS];
    int m_act_bpp  [LAYERS], m_act_en  [LAYERS], m_act_ten  [LAYERS];
    int m_act_tidx [LAYERS], m_act_pal [LAYERS];
    bit m_err;

    logic [EW-1:0] exp_q[$];

    function automatic logic [EW-1:0] obs_vec();
        return {clut_addr, opaque, layer_id, de_out, hsync_out, vsync_out};
    endfunction

    // Expected outputs for the inputs currently on the pins, using the
    // model's active configuration.
    function automatic logic [EW-1:0] model_out();
        int addr = 0;
        int lid  = 0;
        bit op   = 0;
        for (int i = 0; i < LAYERS; i++) begin
            if (!op) begin
                int bpp = m_act_bpp[i];
                int p   = int'(pix_id[i*PIX_IDW +: PIX_IDW]) % (WORD / bpp);
                longint unsigned w = longint'(vram_dout[i*WORD +: WORD]);
                int raw = int'((w >> (p * bpp)) % (64'd1 << bpp));
                if (paint[i] && m_act_en[i] != 0 &&
                    !(m_act_ten[i] != 0 && raw == m_act_tidx[i])) begin
                    op   = 1;
                    addr = (raw + m_act_pal[i]) % (1 << CIDX_ADDRW);
                    lid  = i;
                end
            end
        end
        if (!de_in) begin
            op = 0; addr = 0; lid = 0;
        end
        return {CIDX_ADDRW'(addr), op, 2'(lid), de_in, hsync_in, vsync_in};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LAYERS; i++) begin
            m_pend_bpp[i] = 4; m_pend_en[i] = (i == 0) ? 1 : 0;
            m_pend_ten[i] = 0; m_pend_tidx[i] = 0; m_pend_pal[i] = 0;
            m_act_bpp[i]  = 4; m_act_en[i]  = (i == 0) ? 1 : 0;
            m_act_ten[i]  = 0; m_act_tidx[i]  = 0; m_act_pal[i]  = 0;
        end
        m_err = 0;
    endtask

    task automatic model_cfg();
        if (cfg_we) begin
            int b = int'(cfg_data[3:0]);
            int s = int'(cfg_sel);
            if (s < LAYERS && (b == 1 || b == 2 || b == 4 || b == 8)) begin
                m_pend_bpp[s]  = b;
                m_pend_en[s]   = int'(cfg_data[4]);
                m_pend_ten[s]  = int'(cfg_data[5]);
                m_pend_tidx[s] = int'(cfg_data[15:8]);
                m_pend_pal[s]  = int'(cfg_data[23:16]);
            end else begin
                m_err = 1;
            end
        end
        if (frame_start) begin
            m_act_bpp  = m_pend_bpp;
            m_act_en   = m_pend_en;
            m_act_ten  = m_pend_ten;
            m_act_tidx = m_pend_tidx;
            m_act_pal  = m_pend_pal;
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [EW-1:0] obs,
                         input logic [EW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_now(input string tag, input logic [7:0] addr,
                              input logic op, input logic [1:0] lid);
        check(tag, {8'b0, clut_addr, opaque, layer_id},
              {8'b0, addr, op, lid});
    endtask

    // ---------------- driver tasks ----------------
    // One pixel clock: record expectation for current inputs, advance,
    // then compare the outputs that belong to the inputs of one tick ago.
    task automatic tick();
        exp_q.push_back(model_out());
        model_cfg();
        @(posedge clk_pix);
        #1;
        if (exp_q.size() >= 2) check("pipe", obs_vec(), exp_q.pop_front());
        check_bit("cfg_err", cfg_err, m_err);
        cfg_we      = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_pix     = 1'b1;
        cfg_we      = 1'b0;
        frame_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_pix);
            #1;
            check("rst_out", obs_vec(), '0);
            check_bit("rst_err", cfg_err, 1'b0);
        end
        rst_pix = 1'b0;
        model_reset();
        exp_q.delete();
        // The stage-2 register loads cleared stage-1 state on the first
        // edge after release.
        exp_q.push_back('0);
    endtask

    task automatic set_pix(input int l, input logic [31:0] w, input int pid);
        vram_dout[l*WORD +: WORD]       = w;
        pix_id[l*PIX_IDW +: PIX_IDW]    = PIX_IDW'(pid);
    endtask

    task automatic rand_inputs();
        vram_dout = {$urandom, $urandom};
        pix_id    = LAYERS*PIX_IDW'($urandom);
        paint     = LAYERS'($urandom);
        de_in     = ($urandom_range(0, 3) != 0);
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
        if ($urandom_range(0, 7) == 0) begin
            logic [3:0] b;
            case ($urandom_range(0, 4))
                0: b = 4'd1;
                1: b = 4'd2;
                2: b = 4'd4;
                3: b = 4'd8;
                default: b = 4'($urandom);
            endcase
            cfg_we   = 1'b1;
            cfg_sel  = 2'($urandom_range(0, 3) == 3 ? 2 : $urandom_range(0, 1));
            cfg_data = {8'($urandom), 8'($urandom),
                        ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom),
                        2'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0), b};
        end
        if ($urandom_range(0, 7) == 0) frame_start = 1'b1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_pix = 1'b1; frame_start = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0;
        cfg_data = '0; vram_dout = '0; pix_id = '0; paint = '0;
        de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        model_reset();

        do_reset(3);

        // Default config: layer 0 at 4 bpp, nibble 3 of the word.
        de_in = 1'b1; paint = 2'b01;
        set_pix(0, 32'h7654_3210, 3);
        tick(); tick();
        expect_now("basic_l0", 8'h03, 1'b1, 2'd0);

        // Layer 1 write stays pending until frame_start.
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 32'h0040_0018;
        paint = 2'b10;
        set_pix(1, 32'h00AB_0000, 2);
        tick(); tick(); tick();
        expect_now("pending_hidden", 8'h00, 1'b0, 2'd0);
        frame_start = 1'b1;
        tick(); tick(); tick();
        expect_now("active_l1", 8'hEB, 1'b1, 2'd1);

        // Transparency on layer 0, write and frame_start together.
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 32'h0000_0334; frame_start = 1'b1;
        tick();
        paint = 2'b11;
        set_pix(0, 32'h7654_3210, 3);
        tick(); tick();
        expect_now("trans_hit", 8'hEB, 1'b1, 2'd1);
        set_pix(0, 32'h7654_3210, 2);
        tick(); tick();
        expect_now("trans_miss", 8'h02, 1'b1, 2'd0);

        // Illegal writes: bad bpp, then out-of-range layer.
        cfg_we = 1'b1; cfg_sel = 2'd0; cfg_data = 32'h0000_0013;
        tick();
        check_bit("err_bpp", cfg_err, 1'b1);
        cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 32'h0000_0014;
        tick();
        frame_start = 1'b1;
        tick(); tick(); tick();
        expect_now("cfg_kept", 8'h02, 1'b1, 2'd0);
        check_bit("err_sticky", cfg_err, 1'b1);

        // Same-cycle write + frame_start, palette offset wraps.
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 32'h00F0_0018; frame_start = 1'b1;
        paint = 2'b10;
        set_pix(1, 32'h0000_0020, 0);
        tick(); tick(); tick();
        expect_now("pal_wrap", 8'h10, 1'b1, 2'd1);

        // Blanking zeroes pixel outputs.
        de_in = 1'b0;
        tick(); tick();
        expect_now("de_gate", 8'h00, 1'b0, 2'd0);

        for (int n = 0; n < 400; n++) begin
            rand_inputs();
            tick();
        end

        // Reset in the middle of active video.
        de_in = 1'b1;
        do_reset(1);

        for (int n = 0; n < 300; n++) begin
            rand_inputs();
            tick();
        end
        de_in = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence never completes.
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/canv_mixer.md
CANV_MIXER -- requirements
Module: canv_mixer

Interface
REQ-001 Parameters: LAYERS, default 2, number of canvas layers (1-4).
REQ-002 Parameters: WORD, default 32, vram word width; PIX_IDW, default 5, pixel ID width; CIDX_ADDRW, default 8, colour index width.
REQ-003 Ports: clk_pix  in  1  pixel clock, sole clock; all logic on rising edge.
REQ-004 Ports: rst_pix  in  1  synchronous, active-high reset.
REQ-005 Ports: frame_start  in  1  one-cycle pulse; pending config becomes active.
REQ-006 Ports: cfg_we  in  1  config write strobe; cfg_sel  in  2  target layer; cfg_data  in  32  config word ([3:0] bpp, [4] enable, [5] trans_en, [15:8] trans_idx, [23:16] pal_off).
REQ-007 Ports: vram_dout  in  LAYERS*WORD  per-layer vram word, layer n at bits [n*WORD +: WORD].
REQ-008 Ports: pix_id  in  LAYERS*PIX_IDW  per-layer pixel ID, aligned with vram_dout; paint  in  LAYERS  per-layer window paint, aligned.
REQ-009 Ports: de_in, hsync_in, vsync_in  in  1 each  display timing aligned with vram_dout.
REQ-010 Ports: clut_addr  out  CIDX_ADDRW  CLUT address; opaque  out  1  some layer painted; layer_id  out  2  winning layer.
REQ-011 Ports: de_out, hsync_out, vsync_out  out  1 each  timing delayed to match clut_addr; cfg_err  out  1  sticky config error.

Function
REQ-012 Config write (cfg_we=1, cfg_sel<LAYERS, bpp in {1,2,4,8}) SHALL update that layer's pending register next cycle.
REQ-013 Write with cfg_sel>=LAYERS or bpp not in {1,2,4,8} SHALL be ignored and SHALL set cfg_err, which stays high until reset.
REQ-014 On frame_start, active config SHALL take pending config for all layers; a valid write in the same cycle SHALL be included in the active copy.
REQ-015 Active config SHALL NOT change except at frame_start or reset.
REQ-016 Stage 1 (registered): per layer, raw = (word >> (pid*bpp)) & (2^bpp-1), pid = pix_id masked to log2(WORD/bpp) bits.
REQ-017 Layer visible iff paint & enable & !(trans_en & raw==trans_idx); transparency compares raw index, before offset.
REQ-018 Stage 2 (registered): winner = lowest-numbered visible layer (layer 0 highest priority); clut_addr = (raw + pal_off) mod 2^CIDX_ADDRW; opaque=1; layer_id=winner.
REQ-019 No visible layer: clut_addr=0, opaque=0, layer_id=0.
REQ-020 Latency: inputs at cycle t SHALL appear on all outputs at cycle t+2; timing outputs delayed exactly 2 cycles.
REQ-021 When de pipeline bit is 0, clut_addr, opaque and layer_id SHALL be 0.
REQ-022 Pipeline SHALL accept new data every cycle; no stalls.

Reset
REQ-023 Reset SHALL clear all pipeline registers and outputs to 0, including cfg_err.
REQ-024 Reset SHALL set pending and active config: layer 0 enable=1, bpp=4, others enable=0, bpp=4; all trans_en=0, trans_idx=0, pal_off=0.
REQ-025 Reset mid-frame SHALL take effect next cycle; outputs 0 for 2 cycles after release, then normal.

Structure
REQ-026 Config field offsets, reset config and bpp encodings SHALL live in the shared graphics package.
REQ-027 Per-layer extraction (REQ-016/017) SHALL be one sub-module, canv_pix_extract, instantiated LAYERS times.

Verification
REQ-028 Reset, LAYERS=2, word0=0x76543210, pix_id0=3, paint=01, de=1 -> 2 cycles later clut_addr=0x03, opaque=1, layer_id=0.
REQ-029 Write layer1 bpp=8 enable=1 pal_off=0x40, no frame_start -> layer1 still hidden; after frame_start, word1=0x00AB0000, pix_id1=2, paint=10 -> clut_addr=0xEB, layer_id=1.
REQ-030 Both layers painted, layer0 trans_en=1 trans_idx=3 and raw0=3 -> layer1 wins; raw0=2 -> layer0 wins.
REQ-031 Write bpp=3 or cfg_sel=2 (LAYERS=2) -> config unchanged, cfg_err=1 until rst_pix.
REQ-032 cfg_we and frame_start same cycle -> new value active next cycle; pal_off=0xF0, raw=0x20 -> clut_addr=0x10 (wrap).
REQ-033 Random de/hsync/vsync stream -> outputs equal inputs delayed 2 cycles; de_out=0 forces clut_addr=0.
